// File: rtl/bus_sequencer.sv
// Shared-bus transfer sequencer: arbitrates one requester, drives its bus enable, strobes the target.
// Define BUS_SEQ_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module bus_sequencer #(
    parameter int DATA_W = 12,
    parameter int N_DEV  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_DEV-1:0]     req,
    input  logic [2*N_DEV-1:0]   dst,
    output logic [N_DEV-1:0]     link_bus,
    output logic [N_DEV-1:0]     write,
    input  logic [DATA_W-1:0]    Data_bus,
    output logic [N_DEV-1:0]     done,
    output logic                 err,
    output logic [DATA_W-1:0]    last_data,
    output logic                 busy
);

    localparam int IDX_W = 2;
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [2:0] {IDLE, ARB, DRIVE, STROBE, HOLD, DONE} state_t;

    // The 2-bit dst field per device only addresses four devices.
    if (N_DEV != 4) begin : g_n_dev_check
        $error("bus_sequencer: N_DEV must be 4");
    end

    state_t             state, state_nxt;
    idx_t               src_r, dst_r;
    idx_t               grant_idx, dst_sel, src_nxt, dst_nxt;
    logic               armed;
    logic               req_any;
    logic [N_DEV-1:0]   link_nxt, write_nxt, done_nxt;
    logic               err_nxt;

    assign req_any = |req;
    assign dst_sel = dst[{grant_idx, 1'b0} +: IDX_W];

`ifdef BUS_SEQ_ROUND_ROBIN_EN
    idx_t ptr;

    // Scan downwards so the requester closest to ptr is the last (winning) assignment.
    always_comb begin
        idx_t cand;
        cand      = '0;
        grant_idx = ptr;
        for (int k = N_DEV - 1; k >= 0; k--) begin
            cand = ptr + idx_t'(k);
            if (req[cand]) grant_idx = cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == ARB && req_any) begin
            ptr <= grant_idx + idx_t'(1);
        end
    end
`else
    always_comb begin
        grant_idx = '0;
        for (int k = N_DEV - 1; k >= 0; k--) begin
            if (req[k]) grant_idx = idx_t'(k);
        end
    end
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        link_nxt  = '0;
        write_nxt = '0;
        done_nxt  = '0;
        err_nxt   = 1'b0;
        src_nxt   = (state == ARB) ? grant_idx : src_r;
        dst_nxt   = (state == ARB) ? dst_sel   : dst_r;

        unique case (state)
            IDLE:   if (armed && req_any) state_nxt = ARB;
            ARB: begin
                if (!req_any)                  state_nxt = IDLE;
                else if (dst_sel == grant_idx) state_nxt = DONE;
                else                           state_nxt = DRIVE;
            end
            DRIVE:  state_nxt = STROBE;
            STROBE: state_nxt = HOLD;
            HOLD:   state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded for the state being entered and registered, so write never glitches.
        unique case (state_nxt)
            DRIVE, HOLD: link_nxt[src_nxt] = 1'b1;
            STROBE: begin
                link_nxt[src_nxt]  = 1'b1;
                write_nxt[dst_nxt] = 1'b1;
            end
            DONE: begin
                done_nxt[src_nxt] = 1'b1;
                err_nxt           = (state == ARB);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_r     <= '0;
            dst_r     <= '0;
            armed     <= 1'b0;
            last_data <= '0;
            link_bus  <= '0;
            write     <= '0;
            done      <= '0;
            err       <= 1'b0;
        end else begin
            state    <= state_nxt;
            src_r    <= src_nxt;
            dst_r    <= dst_nxt;
            armed    <= 1'b1;
            link_bus <= link_nxt;
            write    <= write_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            if (state == STROBE) last_data <= Data_bus;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_sequencer.sv
// Randomized self-checking bench for bus_sequencer against a transaction-level model of the sequencing rules.
// Honours BUS_SEQ_ROUND_ROBIN_EN to pick the expected arbitration policy.
module tb_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  dst;
    logic [3:0]  link_bus, write, done;
    logic        err, busy;
    logic [11:0] Data_bus, last_data;

    int n_checks  = 0;
    int n_errors  = 0;
    int model_ptr = 0;
    logic [3:0] prev_link = '0;

    always #5 clk = ~clk;

    bus_sequencer #(.DATA_W(12), .N_DEV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .dst       (dst),
        .link_bus  (link_bus),
        .write     (write),
        .Data_bus  (Data_bus),
        .done      (done),
        .err       (err),
        .last_data (last_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus-protocol invariants, sampled mid-cycle.
    always @(negedge clk) begin
        check("link_onehot0", 32'($onehot0(link_bus)), 1);
        check("write_onehot0", 32'($onehot0(write)), 1);
        if (write != 4'b0)
            check("write_needs_held_link", 32'(link_bus != 4'b0 && link_bus == prev_link), 1);
        prev_link <= link_bus;
    end

    // Arbitration reference: first requester at/after the pointer, or lowest index.
    function automatic int pick(input logic [3:0] r);
`ifdef BUS_SEQ_ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++)
            if (r[(model_ptr + k) % 4]) return (model_ptr + k) % 4;
`else
        for (int k = 0; k < 4; k++)
            if (r[k]) return k;
`endif
        return -1;
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int k = 0; k < 4; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: inputs held; 1: req dropped after ARB; 2: req/dst scrambled after ARB.
    task automatic perturb(input int mode);
        if (mode == 1) req = 4'b0;
        if (mode == 2) begin
            req = 4'($urandom);
            dst = 8'($urandom);
        end
    endtask

    // Called in an IDLE cycle with the sequencer armed; returns to an IDLE cycle.
    task automatic run_xfer(input logic [3:0] r, input logic [7:0] d, input logic [11:0] data,
                            input int mode, output int got_src);
        int s, t;
        logic [3:0] src_oh, dst_oh;
        req      = r;
        dst      = d;
        Data_bus = 12'($urandom);
        s        = pick(r);
        t        = int'(d[2*s +: 2]);
        src_oh   = 4'b1 << s;
        dst_oh   = 4'b1 << t;
        model_ptr = (s + 1) % 4;

        tick();  // ARB
        check("arb_busy", busy, 1);
        check("arb_link", link_bus, 0);
        check("arb_done", done, 0);
        tick();
        perturb(mode);
        if (t == s) begin  // rejected: DONE follows ARB directly
            got_src = oh_idx(done);
            check("rej_err", err, 1);
            check("rej_done", done, src_oh);
            check("rej_link", link_bus, 0);
            check("rej_write", write, 0);
        end else begin
            got_src = oh_idx(link_bus);
            check("drv_link", link_bus, src_oh);
            check("drv_write", write, 0);
            Data_bus = 12'($urandom);
            tick();  // STROBE
            perturb(mode);
            check("stb_link", link_bus, src_oh);
            check("stb_write", write, dst_oh);
            Data_bus = data;
            tick();  // HOLD
            Data_bus = 12'($urandom);
            check("hold_link", link_bus, src_oh);
            check("hold_write", write, 0);
            check("hold_last_data", last_data, data);
            tick();  // DONE
            check("done_pulse", done, src_oh);
            check("done_err", err, 0);
            check("done_link", link_bus, 0);
        end
        if (mode != 0) req = 4'b0;
        tick();  // IDLE
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_err", err, 0);
    endtask

    // Release reset mid-cycle with requests pending; the first edge must not start arbitration.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        check("arm_wait_busy", busy, 0);
    endtask

    initial begin
        int g;
        rst_n    = 1'b0;
        req      = 4'b0;
        dst      = 8'b0;
        Data_bus = 12'b0;
        #12;
        check("rst_link", link_bus, 0);
        check("rst_write", write, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_last_data", last_data, 0);
        release_reset();

        // Four transfers with every device requesting; each targets its neighbour.
        for (int i = 0; i < 4; i++) begin
            run_xfer(4'b1111, 8'b00_11_10_01, 12'($urandom), 0, g);
`ifdef BUS_SEQ_ROUND_ROBIN_EN
            check("grant_order", g, i);
`else
            check("grant_order", g, 0);
`endif
        end

        run_xfer(4'b0001, 8'b0000_0010, 12'h155, 0, g);
        check("basic_src", g, 0);
        run_xfer(4'b0100, 8'b0010_0000, 12'h3a5, 0, g);
        check("reject_src", g, 2);
        run_xfer(4'b0100, 8'b0001_0000, 12'h0f0, 1, g);
        check("drop_src", g, 2);

        // Reset asserted in the middle of STROBE.
        req = 4'b0010;
        dst = 8'b0000_1100;
        tick();  // ARB
        tick();  // DRIVE
        req = 4'b0;
        tick();  // STROBE
        check("pre_rst_write", write, 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_link", link_bus, 0);
        check("mid_rst_write", write, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_last_data", last_data, 0);
        tick();
        check("mid_rst_no_done", done, 0);
        model_ptr = 0;
        release_reset();

        for (int i = 0; i < 40; i++) begin
            run_xfer(4'($urandom_range(1, 15)), 8'($urandom), 12'($urandom),
                     int'($urandom_range(0, 2)), g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
